// File: rtl/zymason_input_cond.sv
// rtl/zymason_input_cond.sv - synchroniser, debouncer and edge strobes for raw switch inputs
module zymason_input_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT     = 8,
  parameter int DEB_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rw_raw,
  input  logic       sel_raw,
  input  logic [3:0] pin_raw,
  output logic       rw,
  output logic       sel,
  output logic [3:0] pin,
  output logic       sel_rise,
  output logic       sel_fall,
  output logic       rw_chg
);

  // Counter value on which a still-differing input is finally accepted.
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  // Synchroniser chain, bit order {rw, sel, pin[3:0]}.
  logic [5:0] r_sync [SYNC_STAGES];

  logic             r_rw;
  logic             r_sel;
  logic [3:0]       r_pin;
  logic [DEB_W-1:0] r_rw_cnt;
  logic [DEB_W-1:0] r_sel_cnt;
  logic [DEB_W-1:0] r_pin_cnt;
  logic             r_rw_chg;
  logic             r_sel_rise;
  logic             r_sel_fall;

  logic [5:0] w_s;
  logic       w_s_rw;
  logic       w_s_sel;
  logic [3:0] w_s_pin;
  logic       w_rw_diff;
  logic       w_sel_diff;
  logic       w_pin_diff;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_s_rw  = w_s[5];
  assign w_s_sel = w_s[4];
  assign w_s_pin = w_s[3:0];

  // PIN is judged as a group: any differing bit keeps its counter running.
  assign w_rw_diff  = (w_s_rw  != r_rw);
  assign w_sel_diff = (w_s_sel != r_sel);
  assign w_pin_diff = (w_s_pin != r_pin);

  // Plain flop chain per raw bit; nothing between stages.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {rw_raw, sel_raw, pin_raw};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // RW debounce: accept after DEB_CNT consecutive differing cycles, strobe on any change.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rw     <= 1'b0;
      r_rw_cnt <= '0;
      r_rw_chg <= 1'b0;
    end else begin
      r_rw_chg <= 1'b0;
      if (!w_rw_diff) begin
        r_rw_cnt <= '0;
      end else if (r_rw_cnt == DEB_LAST) begin
        r_rw     <= w_s_rw;
        r_rw_cnt <= '0;
        r_rw_chg <= 1'b1;
      end else begin
        r_rw_cnt <= r_rw_cnt + DEB_W'(1);
      end
    end
  end

  // SEL debounce: same rule, with direction-specific strobes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sel      <= 1'b0;
      r_sel_cnt  <= '0;
      r_sel_rise <= 1'b0;
      r_sel_fall <= 1'b0;
    end else begin
      r_sel_rise <= 1'b0;
      r_sel_fall <= 1'b0;
      if (!w_sel_diff) begin
        r_sel_cnt <= '0;
      end else if (r_sel_cnt == DEB_LAST) begin
        r_sel      <= w_s_sel;
        r_sel_cnt  <= '0;
        r_sel_rise <= w_s_sel;
        r_sel_fall <= ~w_s_sel;
      end else begin
        r_sel_cnt <= r_sel_cnt + DEB_W'(1);
      end
    end
  end

  // PIN debounce: the value loaded is whatever is synchronised on the accept cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pin     <= 4'h0;
      r_pin_cnt <= '0;
    end else begin
      if (!w_pin_diff) begin
        r_pin_cnt <= '0;
      end else if (r_pin_cnt == DEB_LAST) begin
        r_pin     <= w_s_pin;
        r_pin_cnt <= '0;
      end else begin
        r_pin_cnt <= r_pin_cnt + DEB_W'(1);
      end
    end
  end

  assign rw       = r_rw;
  assign sel      = r_sel;
  assign pin      = r_pin;
  assign rw_chg   = r_rw_chg;
  assign sel_rise = r_sel_rise;
  assign sel_fall = r_sel_fall;

endmodule

// File: tb/tb_zymason_input_cond.sv
// tb/tb_zymason_input_cond.sv - self-checking bench for zymason_input_cond
module tb_zymason_input_cond;

  localparam int SS = 2;
  localparam int DC = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rw_raw = 1'b1;
  logic       sel_raw = 1'b1;
  logic [3:0] pin_raw = 4'hF;
  logic       rw;
  logic       sel;
  logic [3:0] pin;
  logic       sel_rise;
  logic       sel_fall;
  logic       rw_chg;

  int n_checks = 0;
  int n_errors = 0;

  zymason_input_cond #(.SYNC_STAGES(SS), .DEB_CNT(DC), .DEB_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .rw_raw   (rw_raw),
    .sel_raw  (sel_raw),
    .pin_raw  (pin_raw),
    .rw       (rw),
    .sel      (sel),
    .pin      (pin),
    .sel_rise (sel_rise),
    .sel_fall (sel_fall),
    .rw_chg   (rw_chg)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw inputs are delayed SS edges, and an output takes the
  // synchronised value once the last DC synchronised samples all differ from it
  // and at least DC edges have passed since its last change (or reset).
  logic [5:0] m_pipe [SS];
  logic [5:0] m_hist [DC];
  int         m_age [3];
  logic       m_rw = 1'b0, m_sel = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_chg = 1'b0;
  logic [3:0] m_pin = 4'h0;
  bit         m_valid = 1'b0;

  initial begin
    forever begin
      logic [5:0] s;
      bit d_rw, d_sel, d_pin;
      @(posedge clock);
      if (!reset) begin
        for (int i = 0; i < SS; i++) m_pipe[i] = '0;
        for (int k = 0; k < DC; k++) m_hist[k] = '0;
        for (int c = 0; c < 3; c++) m_age[c] = 0;
        m_rw = 0; m_sel = 0; m_pin = 0; m_rise = 0; m_fall = 0; m_chg = 0;
        m_valid = 1'b1;
      end else begin
        s = m_pipe[SS-1];
        for (int k = DC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s;
        for (int c = 0; c < 3; c++) m_age[c]++;
        d_rw = 1; d_sel = 1; d_pin = 1;
        for (int k = 0; k < DC; k++) begin
          if (m_hist[k][5] == m_rw) d_rw = 0;
          if (m_hist[k][4] == m_sel) d_sel = 0;
          if (m_hist[k][3:0] == m_pin) d_pin = 0;
        end
        m_rise = 0; m_fall = 0; m_chg = 0;
        if (d_rw && m_age[0] >= DC) begin
          m_rw = s[5]; m_chg = 1; m_age[0] = 0;
        end
        if (d_sel && m_age[1] >= DC) begin
          m_sel = s[4]; m_rise = s[4]; m_fall = ~s[4]; m_age[1] = 0;
        end
        if (d_pin && m_age[2] >= DC) begin
          m_pin = s[3:0]; m_age[2] = 0;
        end
        for (int i = SS-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = {rw_raw, sel_raw, pin_raw};
      end
    end
  end

  // Per-cycle comparison against the model, plus strobe tallies used by directed tests.
  int  rise_cnt = 0;
  int  fall_cnt = 0;
  int  chg_cnt = 0;
  bit  watch3 = 0;
  bit  seen3 = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        chk("outputs_vs_model", {23'd0, rw, sel, pin, sel_rise, sel_fall, rw_chg},
            {23'd0, m_rw, m_sel, m_pin, m_rise, m_fall, m_chg});
        chk("rise_fall_exclusive", {31'd0, sel_rise & sel_fall}, 32'd0);
        if (sel_rise) rise_cnt++;
        if (sel_fall) fall_cnt++;
        if (rw_chg) chg_cnt++;
        if (watch3 && pin == 4'h3) seen3 = 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  int r0, f0, c0;

  initial begin
    // 1: reset with raw inputs high, then power-up rise after 10 edges
    step(3);
    chk("reset_outs", {26'd0, rw, sel, pin}, 32'd0);
    chk("reset_strobes", {29'd0, sel_rise, sel_fall, rw_chg}, 32'd0);
    reset = 1;
    step(9);
    chk("pwr_rw_before", {31'd0, rw}, 32'd0);
    step(1);
    chk("pwr_rw", {31'd0, rw}, 32'd1);
    chk("pwr_sel", {31'd0, sel}, 32'd1);
    chk("pwr_pin", {28'd0, pin}, 32'h0F);
    chk("pwr_strobes", {29'd0, sel_rise, sel_fall, rw_chg}, 32'b101);
    step(1);
    chk("pwr_strobes_clear", {29'd0, sel_rise, sel_fall, rw_chg}, 32'd0);

    // 2: clean sel fall then rise
    sel_raw = 0;
    step(9);
    chk("sel_fall_before", {31'd0, sel}, 32'd1);
    step(1);
    chk("sel_fall_lvl", {30'd0, sel, sel_fall}, 32'b01);
    sel_raw = 1;
    step(9);
    chk("sel_rise_before", {31'd0, sel}, 32'd0);
    step(1);
    chk("sel_rise_lvl", {30'd0, sel, sel_rise}, 32'b11);

    // 3: bounce on sel_raw, then hold high
    sel_raw = 0;
    step(12);
    r0 = rise_cnt; f0 = fall_cnt;
    sel_raw = 1; step(3);
    sel_raw = 0; step(3);
    sel_raw = 1; step(3);
    sel_raw = 0; step(3);
    sel_raw = 1;
    chk("bounce_no_toggle", {31'd0, sel}, 32'd0);
    step(9);
    chk("bounce_before", {31'd0, sel}, 32'd0);
    step(1);
    chk("bounce_rise", {30'd0, sel, sel_rise}, 32'b11);
    step(5);
    chk("bounce_rise_count", rise_cnt - r0, 32'd1);
    chk("bounce_fall_count", fall_cnt - f0, 32'd0);

    // 4: short and long rw pulses
    rw_raw = 0;
    step(12);
    c0 = chg_cnt;
    rw_raw = 1; step(7);
    rw_raw = 0; step(15);
    chk("rw_short_pulse", chg_cnt - c0, 32'd0);
    chk("rw_short_lvl", {31'd0, rw}, 32'd0);
    rw_raw = 1; step(8);
    rw_raw = 0; step(20);
    chk("rw_long_pulse", chg_cnt - c0, 32'd2);

    // 5: pin 0 -> 3 (4 cycles) -> 5 held
    pin_raw = 4'h0;
    step(12);
    watch3 = 1;
    pin_raw = 4'h3; step(4);
    pin_raw = 4'h5; step(5);
    chk("pin_before", {28'd0, pin}, 32'h0);
    step(1);
    chk("pin_accept", {28'd0, pin}, 32'h5);
    step(4);
    watch3 = 0;
    chk("pin_never_3", {31'd0, seen3}, 32'd0);

    // 6: reset mid-debounce discards pending sel change
    sel_raw = 0;
    step(12);
    sel_raw = 1;
    step(7);
    reset = 0;
    step(2);
    chk("rst_mid_sel", {31'd0, sel}, 32'd0);
    reset = 1;
    step(9);
    chk("rst_mid_before", {31'd0, sel}, 32'd0);
    step(1);
    chk("rst_mid_after", {30'd0, sel, sel_rise}, 32'b11);

    // Random phase: varied hold lengths straddle the debounce threshold.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 0;
        step($urandom_range(1, 3));
        reset = 1;
      end
      case ($urandom_range(0, 2))
        0: rw_raw = ~rw_raw;
        1: sel_raw = ~sel_raw;
        default: pin_raw = 4'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) pin_raw = 4'($urandom);
      step($urandom_range(1, 12));
    end
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
